// File: rtl/cbus_sram_responder_pkg.sv
// rtl/cbus_sram_responder_pkg.sv - shared cache-bus types and responder helpers
// Contents: cbus_req_t / cbus_resp_t transaction structs, axi_len_t burst
// length, MSIZE*/MLEN* encodings, responder FSM state enum, and helpers that
// validate a burst length and turn it into the address wrap mask.
package cbus_sram_responder_pkg;

  typedef logic [3:0] axi_len_t;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;

  localparam axi_len_t MLEN1  = 4'd0;
  localparam axi_len_t MLEN2  = 4'd1;
  localparam axi_len_t MLEN4  = 4'd3;
  localparam axi_len_t MLEN8  = 4'd7;
  localparam axi_len_t MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    axi_len_t    len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} cbus_rsp_state_t;

  function automatic logic len_legal(input axi_len_t len);
    return (len == MLEN1) || (len == MLEN2) || (len == MLEN4) ||
           (len == MLEN8) || (len == MLEN16);
  endfunction

  // Legal lengths are 2^n-1, so the length itself is the mask of counting
  // address bits; an illegal length collapses to a single beat.
  function automatic axi_len_t wrap_mask(input axi_len_t len);
    return len_legal(len) ? len : MLEN1;
  endfunction

endpackage

// File: rtl/cbus_sram_responder_lfsr8.sv
// rtl/cbus_sram_responder_lfsr8.sv - 8-bit maximal LFSR used as a beat-stall source
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous active-high reset, loads SEED
//   lfsr_o  out  current LFSR state; bit 0 requests a stall this cycle
module cbus_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/cbus_sram_responder.sv
// rtl/cbus_sram_responder.sv - cache-bus responder backed by a 1-cycle synchronous SRAM
// Optional macro: CBUS_RESP_STALL_EN inserts LFSR-driven gaps between beats.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   creq       in   cbus_req_t request (valid, is_write, size, addr, strobe, data, len)
//   cresp      out  cbus_resp_t response (ready, last, data)
//   mem_en     out  SRAM access enable
//   mem_we     out  SRAM byte write enables
//   mem_addr   out  SRAM word address
//   mem_wdata  out  SRAM write data
//   mem_rdata  in   SRAM read data, valid the cycle after a read
//   err_proto  out  sticky protocol-violation flag
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int         MEM_AW    = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  cbus_req_t         creq,
  output cbus_resp_t        cresp,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err_proto
);

  cbus_rsp_state_t   state_q;
  logic [MEM_AW-1:0] base_q;
  axi_len_t          len_q;
  logic [4:0]        cnt_q;     // RD: reads issued; WR: beats written
  axi_len_t          pres_q;    // RD: beats handed to the initiator
  logic              rvalid_q;  // a read was issued last cycle
  logic              bufv_q;    // read data parked while a beat is stalled
  logic [31:0]       buf_q;
  logic              err_q;
  logic              stall;

`ifdef CBUS_RESP_STALL_EN
  logic [7:0] lfsr;
  logic [6:0] unused_lfsr;

  cbus_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i  (clk),
    .rst_i  (reset),
    .lfsr_o (lfsr)
  );

  assign stall       = lfsr[0];
  assign unused_lfsr = lfsr[7:1];
`else
  logic [7:0] unused_seed;

  assign stall       = 1'b0;
  assign unused_seed = LFSR_SEED;
`endif

  logic unused_bits;
  assign unused_bits = ^{creq.size, creq.addr[31:MEM_AW+2], creq.addr[1:0]};

  // Low address bits selected by the mask count and wrap; upper bits hold.
  logic [3:0]        low_sum;
  logic [MEM_AW-1:0] beat_addr;
  assign low_sum   = base_q[3:0] + cnt_q[3:0];
  assign beat_addr = {base_q[MEM_AW-1:4], (base_q[3:0] & ~len_q) | (low_sum & len_q)};

  logic rd_issue;
  logic rd_present;
  logic wr_beat;
  assign rd_issue   = (state_q == RD) && (cnt_q <= {1'b0, len_q}) && !stall;
  assign rd_present = (state_q == RD) && (rvalid_q || bufv_q) && !stall;
  // A dropped valid suppresses the write in the same cycle it is seen.
  assign wr_beat    = (state_q == WR) && creq.valid && !stall;

  assign mem_en     = rd_issue || wr_beat;
  assign mem_we     = wr_beat ? creq.strobe : 4'b0000;
  assign mem_wdata  = wr_beat ? creq.data : 32'd0;
  assign mem_addr   = mem_en ? beat_addr : '0;

  assign cresp.ready = rd_present || wr_beat;
  assign cresp.last  = (rd_present && (pres_q == len_q)) ||
                       (wr_beat && (cnt_q[3:0] == len_q));
  assign cresp.data  = rd_present ? (bufv_q ? buf_q : mem_rdata) : 32'd0;
  assign err_proto   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= MLEN1;
      cnt_q    <= 5'd0;
      pres_q   <= 4'd0;
      rvalid_q <= 1'b0;
      bufv_q   <= 1'b0;
      buf_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (creq.valid) begin
            base_q   <= creq.addr[MEM_AW+1:2];
            len_q    <= wrap_mask(creq.len);
            cnt_q    <= 5'd0;
            pres_q   <= 4'd0;
            rvalid_q <= 1'b0;
            bufv_q   <= 1'b0;
            if (!len_legal(creq.len)) err_q <= 1'b1;
            state_q  <= creq.is_write ? WR : RD;
          end
        end
        RD: begin
          if (rd_present && cresp.last) begin
            rvalid_q <= 1'b0;
            bufv_q   <= 1'b0;
            state_q  <= DONE;
          end else if (!creq.valid) begin
            rvalid_q <= 1'b0;
            bufv_q   <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= IDLE;
          end else begin
            rvalid_q <= rd_issue;
            if (rd_issue) cnt_q <= cnt_q + 5'd1;
            if (rd_present) begin
              pres_q <= pres_q + 4'd1;
              bufv_q <= 1'b0;
            end else if (stall && rvalid_q) begin
              // Data arriving during a stall would be lost; park it.
              buf_q  <= mem_rdata;
              bufv_q <= 1'b1;
            end
          end
        end
        WR: begin
          if (!creq.valid) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (wr_beat) begin
            if (cresp.last) state_q <= DONE;
            else            cnt_q   <= cnt_q + 5'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// tb/tb_cbus_sram_responder.sv - scoreboard bench for cbus_sram_responder with a behavioural SRAM
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  cbus_req_t   creq;
  cbus_resp_t  cresp;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        err_proto;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sram [0:65535];
  logic [31:0] wdat [16];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  cbus_sram_responder #(.MEM_AW(16), .LFSR_SEED(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .creq      (creq),
    .cresp     (cresp),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err_proto (err_proto)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

`ifdef CBUS_RESP_STALL_EN
  logic [7:0] tb_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_lfsr <= 8'hA5;
    else       tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input axi_len_t len, input string tag);
    int cyc;
    int first_cyc;
    int prev_cyc;
    logic got_last;
    logic [31:0] exp;
    cyc = 0; first_cyc = -1; prev_cyc = -1; got_last = 1'b0;
    @(posedge clk); #1;
    creq = '0;
    creq.valid = 1'b1;
    creq.size  = MSIZE4;
    creq.addr  = addr;
    creq.len   = len;
    while (!got_last && cyc < 200) begin
      @(negedge clk);
`ifdef CBUS_RESP_STALL_EN
      if (tb_lfsr[0]) chk({tag, "_gap"}, 32'(cresp.ready), 32'd0);
`endif
      if (cresp.ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_beat"}, 32'd1, 32'd0);
          got_last = 1'b1;
        end else begin
          exp = exp_q.pop_front();
          chk({tag, "_data"}, cresp.data, exp);
          chk({tag, "_last"}, 32'(cresp.last), 32'(exp_q.size() == 0));
`ifndef CBUS_RESP_STALL_EN
          if (first_cyc < 0) chk({tag, "_latency"}, 32'(cyc), 32'd2);
          else               chk({tag, "_spacing"}, 32'(cyc - prev_cyc), 32'd1);
`endif
          if (first_cyc < 0) first_cyc = cyc;
          prev_cyc = cyc;
          got_last = cresp.last;
        end
      end
      cyc++;
    end
    if (!got_last) chk({tag, "_timeout"}, 32'd0, 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    creq.valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_idle"}, 32'(cresp.ready), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input axi_len_t len, input logic [3:0] strb,
                          input int drop_after, input string tag);
    int beat;
    int cyc;
    logic done;
    beat = 0; cyc = 0; done = 1'b0;
    @(posedge clk); #1;
    creq = '0;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.size     = MSIZE4;
    creq.addr     = addr;
    creq.len      = len;
    creq.strobe   = strb;
    creq.data     = wdat[0];
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (cresp.ready) begin
        chk({tag, "_last"}, 32'(cresp.last), 32'(beat == int'(len)));
        done = cresp.last;
        beat++;
      end
      @(posedge clk); #1;
      if (beat == drop_after) done = 1'b1;
      else if (!done && beat < 16) creq.data = wdat[beat];
      cyc++;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    creq.valid = 1'b0;
    if (drop_after < 0) begin
      @(negedge clk);
      chk({tag, "_done_idle"}, 32'(cresp.ready), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset = 1'b1;
    creq  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(cresp.ready), 32'd0);
    chk("reset_data", cresp.data, 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_err", 32'(err_proto), 32'd0);
    reset = 1'b0;

    sram[16'h40] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    do_read(32'h100, MLEN1, "rd1");

    for (int i = 0; i < 4; i++) sram[16'h40 + i] = 32'(i);
    exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    do_read(32'h108, MLEN4, "rd4wrap");

    for (int i = 0; i < 16; i++) wdat[i] = 32'(i);
    do_write(32'h200, MLEN16, 4'hF, -1, "wr16");
    for (int i = 0; i < 16; i++) chk("wr16_mem", sram[16'h80 + i], 32'(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    do_read(32'h200, MLEN16, "rb16");
    chk("err_clean", 32'(err_proto), 32'd0);

    sram[16'h10] = 32'h11223344;
    wdat[0] = 32'h00AA0000;
    do_write(32'h40, MLEN1, 4'b0100, -1, "wrbyte");
    chk("wrbyte_mem", sram[16'h10], 32'h11AA3344);
    exp_q.push_back(32'h11AA3344);
    do_read(32'h40, MLEN1, "rbbyte");

    sram[0] = 32'h5A5A0000; sram[1] = 32'h5A5A0001; sram[2] = 32'h5A5A0002;
    for (int i = 0; i < 16; i++) wdat[i] = 32'hA0 + 32'(i);
    do_write(32'h0, MLEN8, 4'hF, 2, "viol");
    repeat (3) @(negedge clk);
    chk("viol_word0", sram[0], 32'hA0);
    chk("viol_word1", sram[1], 32'hA1);
    chk("viol_word2", sram[2], 32'h5A5A0002);
    chk("viol_err", 32'(err_proto), 32'd1);

    @(posedge clk); #1;
    creq = '0;
    creq.valid = 1'b1;
    creq.len   = MLEN16;
    cyc = 0;
    @(negedge clk);
    while (!cresp.ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_started", 32'(cresp.ready), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(cresp.ready), 32'd0);
    chk("rst_mid_data", cresp.data, 32'd0);
    chk("rst_mid_err", 32'(err_proto), 32'd0);
    creq.valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_edge_ready", 32'(cresp.ready), 32'd0);
    chk("rst_edge_mem_en", 32'(mem_en), 32'd0);
    reset = 1'b0;

    sram[16'h40] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    do_read(32'h100, 4'd5, "rdbadlen");
    chk("badlen_err", 32'(err_proto), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
